// File: rtl/robot_motion_sequencer.sv
// Robot motion sequencer: sense / command / drive / settle loop
// with emergency stop and saturating step counters.
module robot_motion_sequencer #(
  parameter int FWD_CYCLES    = 4,
  parameter int TURN_CYCLES   = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       estop,
  input  logic       cmd_valid,
  input  logic       front,
  input  logic       turn,
  output logic       sense_req,
  output logic       cmd_ready,
  output logic       motor_fwd,
  output logic       motor_turn,
  output logic       busy,
  output logic [7:0] fwd_count,
  output logic [7:0] turn_count
);

  // A zero-length phase would never terminate; stretch it to one cycle.
  localparam int FWD_N  = (FWD_CYCLES    < 1) ? 1 : FWD_CYCLES;
  localparam int TURN_N = (TURN_CYCLES   < 1) ? 1 : TURN_CYCLES;
  localparam int SET_N  = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;

  localparam int MAX_FT = (FWD_N > TURN_N) ? FWD_N : TURN_N;
  localparam int TMAX   = (MAX_FT > SET_N) ? MAX_FT : SET_N;
  localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] FWD_LAST  = TW'(FWD_N - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_N - 1);
  localparam logic [TW-1:0] SET_LAST  = TW'(SET_N - 1);

  typedef enum logic [2:0] {
    IDLE,
    SENSE,
    WAIT_CMD,
    DRIVE,
    ROTATE,
    SETTLE
  } state_t;

  state_t        state_q;
  state_t        state_n;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_n;
  logic          fwd_inc;
  logic          turn_inc;

  logic          sense_req_q;
  logic          cmd_ready_q;
  logic          motor_fwd_q;
  logic          motor_turn_q;
  logic          busy_q;
  logic [7:0]    fwd_count_q;
  logic [7:0]    turn_count_q;

  // Next-state, step timer and step-completion strobes.
  always_comb begin
    state_n  = state_q;
    timer_n  = timer_q;
    fwd_inc  = 1'b0;
    turn_inc = 1'b0;
    if (estop) begin
      state_n = IDLE;
      timer_n = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable) begin
            state_n = SENSE;
          end
        end
        SENSE: begin
          state_n = WAIT_CMD;
        end
        WAIT_CMD: begin
          if (cmd_valid) begin
            timer_n = '0;
            if (turn) begin
              state_n = ROTATE;
            end else if (front) begin
              state_n = DRIVE;
            end else begin
              state_n = SETTLE;
            end
          end else if (!enable) begin
            state_n = IDLE;
          end
        end
        DRIVE: begin
          if (timer_q == FWD_LAST) begin
            state_n = SETTLE;
            timer_n = '0;
            fwd_inc = 1'b1;
          end else begin
            timer_n = timer_q + 1'b1;
          end
        end
        ROTATE: begin
          if (timer_q == TURN_LAST) begin
            state_n  = SETTLE;
            timer_n  = '0;
            turn_inc = 1'b1;
          end else begin
            timer_n = timer_q + 1'b1;
          end
        end
        SETTLE: begin
          if (timer_q == SET_LAST) begin
            timer_n = '0;
            state_n = enable ? SENSE : IDLE;
          end else begin
            timer_n = timer_q + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          timer_n = '0;
        end
      endcase
    end
  end

  // State and step timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_n;
      timer_q <= timer_n;
    end
  end

  // Outputs are decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sense_req_q  <= 1'b0;
      cmd_ready_q  <= 1'b0;
      motor_fwd_q  <= 1'b0;
      motor_turn_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sense_req_q  <= (state_n == SENSE);
      cmd_ready_q  <= (state_n == WAIT_CMD);
      motor_fwd_q  <= (state_n == DRIVE);
      motor_turn_q <= (state_n == ROTATE);
      busy_q       <= (state_n != IDLE);
    end
  end

  // Saturating completed-step counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_count_q  <= 8'd0;
      turn_count_q <= 8'd0;
    end else begin
      if (fwd_inc && (fwd_count_q != 8'hFF)) begin
        fwd_count_q <= fwd_count_q + 8'd1;
      end
      if (turn_inc && (turn_count_q != 8'hFF)) begin
        turn_count_q <= turn_count_q + 8'd1;
      end
    end
  end

  assign sense_req  = sense_req_q;
  assign cmd_ready  = cmd_ready_q;
  assign motor_fwd  = motor_fwd_q;
  assign motor_turn = motor_turn_q;
  assign busy       = busy_q;
  assign fwd_count  = fwd_count_q;
  assign turn_count = turn_count_q;

  // The two drives must never fight each other.
  a_motor_excl: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(motor_fwd && motor_turn)
  );

endmodule

// File: tb/tb_robot_motion_sequencer.sv
// Directed bench for robot_motion_sequencer.
// Vector table plus estop, reset and saturation sequences.
module tb_robot_motion_sequencer;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       estop;
  logic       cmd_valid;
  logic       front;
  logic       turn;
  logic       sense_req;
  logic       cmd_ready;
  logic       motor_fwd;
  logic       motor_turn;
  logic       busy;
  logic [7:0] fwd_count;
  logic [7:0] turn_count;

  int total;
  int bad;
  int both_cnt;

  typedef struct {
    bit       en;
    bit       es;
    bit       cv;
    bit       fr;
    bit       tu;
    bit       s;
    bit       r;
    bit       mf;
    bit       mt;
    bit       b;
    bit [7:0] fc;
    bit [7:0] tc;
  } vec_t;

  vec_t vq[$];

  robot_motion_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .estop     (estop),
    .cmd_valid (cmd_valid),
    .front     (front),
    .turn      (turn),
    .sense_req (sense_req),
    .cmd_ready (cmd_ready),
    .motor_fwd (motor_fwd),
    .motor_turn(motor_turn),
    .busy      (busy),
    .fwd_count (fwd_count),
    .turn_count(turn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && motor_fwd && motor_turn) both_cnt++;
  end

  function automatic vec_t mk(
    bit en, bit es, bit cv, bit fr, bit tu,
    bit s, bit r, bit mf, bit mt, bit b,
    int fc, int tc
  );
    vec_t v;
    v.en = en; v.es = es; v.cv = cv; v.fr = fr; v.tu = tu;
    v.s = s; v.r = r; v.mf = mf; v.mt = mt; v.b = b;
    v.fc = fc[7:0]; v.tc = tc[7:0];
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [20:0] outs();
    return {sense_req, cmd_ready, motor_fwd, motor_turn, busy,
            fwd_count, turn_count};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(bit en, bit es, bit cv, bit fr, bit tu);
    enable = en; estop = es; cmd_valid = cv; front = fr; turn = tu;
  endtask

  initial begin
    int n;
    total = 0;
    bad = 0;
    both_cnt = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);

    // en es cv fr tu | s r mf mt b fc tc
    vq.push_back(mk(1,0,0,0,0, 1,0,0,0,1, 0,0));
    vq.push_back(mk(1,0,0,0,0, 0,1,0,0,1, 0,0));
    vq.push_back(mk(1,0,0,0,0, 0,1,0,0,1, 0,0));
    vq.push_back(mk(1,0,1,1,0, 0,0,1,0,1, 0,0));
    for (int i = 0; i < 3; i++)
      vq.push_back(mk(1,0,0,0,0, 0,0,1,0,1, 0,0));
    vq.push_back(mk(1,0,0,0,0, 0,0,0,0,1, 1,0));
    vq.push_back(mk(1,0,0,0,0, 0,0,0,0,1, 1,0));
    vq.push_back(mk(1,0,0,0,0, 1,0,0,0,1, 1,0));
    vq.push_back(mk(1,0,0,0,0, 0,1,0,0,1, 1,0));
    vq.push_back(mk(1,0,1,1,1, 0,0,0,1,1, 1,0));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(1,0,0,0,0, 0,0,0,1,1, 1,0));
    for (int i = 0; i < 2; i++)
      vq.push_back(mk(0,0,0,0,0, 0,0,0,1,1, 1,0));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0,1, 1,1));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0,1, 1,1));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 1,1));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 1,1));
    vq.push_back(mk(1,0,0,0,0, 1,0,0,0,1, 1,1));
    vq.push_back(mk(1,0,0,0,0, 0,1,0,0,1, 1,1));
    vq.push_back(mk(1,0,1,0,0, 0,0,0,0,1, 1,1));
    vq.push_back(mk(1,0,0,0,0, 0,0,0,0,1, 1,1));
    vq.push_back(mk(1,0,0,0,0, 1,0,0,0,1, 1,1));
    vq.push_back(mk(1,0,0,0,0, 0,1,0,0,1, 1,1));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 1,1));
    vq.push_back(mk(1,1,0,0,0, 0,0,0,0,0, 1,1));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 1,1));

    repeat (2) @(negedge clk);
    chk("reset_state", 32'(outs()), 32'd0);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].en, vq[i].es, vq[i].cv, vq[i].fr, vq[i].tu);
      step();
      chk($sformatf("vec%0d", i), 32'(outs()),
          32'({vq[i].s, vq[i].r, vq[i].mf, vq[i].mt, vq[i].b,
               vq[i].fc, vq[i].tc}));
    end

    // estop on the third ROTATE cycle
    drive(1, 0, 0, 0, 0);
    step();
    step();
    drive(1, 0, 1, 0, 1);
    step();
    chk("rot_c1_turn", 32'(motor_turn), 32'd1);
    drive(1, 0, 0, 0, 0);
    step();
    step();
    chk("rot_c3_turn", 32'(motor_turn), 32'd1);
    drive(1, 1, 0, 0, 0);
    step();
    chk("estop_outs", 32'(outs()), 32'({5'b00000, 8'd1, 8'd1}));
    drive(0, 0, 0, 0, 0);
    step();
    chk("estop_idle_busy", 32'(busy), 32'd0);

    // full rotate after estop: timer must restart
    drive(1, 0, 0, 0, 0);
    step();
    step();
    drive(1, 0, 1, 0, 1);
    step();
    drive(0, 0, 0, 0, 0);
    n = 0;
    for (int k = 0; k < 20 && motor_turn; k++) begin
      n++;
      step();
    end
    chk("rot_len_after_estop", 32'(n), 32'd8);
    chk("turn_count_2", 32'(turn_count), 32'd2);
    chk("fwd_count_kept", 32'(fwd_count), 32'd1);

    // reset pulse in the middle of DRIVE
    repeat (4) step();
    drive(1, 0, 1, 1, 0);
    n = 0;
    for (int k = 0; k < 20 && !motor_fwd; k++) begin
      n++;
      step();
    end
    chk("drive_reached", 32'(motor_fwd), 32'd1);
    step();
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_drive", 32'(outs()), 32'd0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("after_reset_idle", 32'(outs()), 32'd0);

    // 260 forward steps, 8 cycles each
    drive(1, 0, 1, 1, 0);
    repeat (260 * 8 + 4) step();
    chk("fwd_saturate", 32'(fwd_count), 32'd255);
    chk("turn_zero_sat", 32'(turn_count), 32'd0);
    drive(0, 0, 0, 0, 0);
    repeat (10) step();
    chk("final_idle_busy", 32'(busy), 32'd0);
    chk("motor_exclusive", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/robot_motion_sequencer.md
ROBOT_MOTION_SEQUENCER -- requirements
Module: robot_motion_sequencer

Interface
REQ-001 SHALL have parameter FWD_CYCLES, default 4: cycles motor_fwd is held per forward step.
REQ-002 SHALL have parameter TURN_CYCLES, default 8: cycles motor_turn is held per turn step.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 2: idle cycles after each step, before the next sensor sample.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port enable, input, 1: run request; level-sensitive.
REQ-007 SHALL have port estop, input, 1: emergency stop; synchronous, highest priority.
REQ-008 SHALL have port cmd_valid, input, 1: front/turn command from the navigation FSM is valid.
REQ-009 SHALL have port front, input, 1: command to advance one step.
REQ-010 SHALL have port turn, input, 1: command to rotate one step.
REQ-011 SHALL have port sense_req, output, 1: one-cycle strobe; the navigation FSM samples its sensors and updates its state.
REQ-012 SHALL have port cmd_ready, output, 1: sequencer accepts a command this cycle.
REQ-013 SHALL have port motor_fwd, output, 1: forward drive enable.
REQ-014 SHALL have port motor_turn, output, 1: rotate drive enable.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-016 SHALL have port fwd_count, output, 8: count of completed forward steps.
REQ-017 SHALL have port turn_count, output, 8: count of completed turn steps.

Function
REQ-018 SHALL implement the states IDLE, SENSE, WAIT_CMD, DRIVE, ROTATE and SETTLE.
REQ-019 SHALL register all outputs; no output depends combinationally on any input.
REQ-020 SHALL, in IDLE with enable=1 and estop=0, go to SENSE on the next edge; all outputs except the counters are low while in IDLE.
REQ-021 SHALL, in SENSE, assert sense_req for exactly one cycle, then go to WAIT_CMD.
REQ-022 SHALL, in WAIT_CMD, hold cmd_ready=1; a command is accepted only when cmd_valid=1 and cmd_ready=1 in the same cycle.
REQ-023 SHALL, on acceptance, go to ROTATE if turn=1 (turn has priority when front=1 and turn=1), else to DRIVE if front=1, else to SETTLE as a no-op.
REQ-024 SHALL, when in WAIT_CMD with enable=0 and cmd_valid=0, return to IDLE; when cmd_valid=1, the accept rule of REQ-023 wins.
REQ-025 SHALL hold motor_fwd=1 for exactly FWD_CYCLES consecutive cycles in DRIVE, then go to SETTLE.
REQ-026 SHALL hold motor_turn=1 for exactly TURN_CYCLES consecutive cycles in ROTATE, then go to SETTLE.
REQ-027 SHALL never assert motor_fwd and motor_turn in the same cycle.
REQ-028 SHALL increment fwd_count or turn_count by 1 on the last cycle of DRIVE or ROTATE respectively; both counters saturate at 255 and do not wrap.
REQ-029 SHALL, in SETTLE, keep the motors low for SETTLE_CYCLES cycles, then go to SENSE if enable=1, else to IDLE.
REQ-030 SHALL, when enable drops during DRIVE or ROTATE, complete the step and the settle period, then go to IDLE.
REQ-031 SHALL, on estop=1 in any state, go to IDLE on the next edge with all motors low; an interrupted step does not increment any counter.
REQ-032 SHALL treat parameter value 0 as 1 for FWD_CYCLES, TURN_CYCLES and SETTLE_CYCLES.

Reset
REQ-033 SHALL, on rst_n=0, immediately force state=IDLE, sense_req=0, cmd_ready=0, motor_fwd=0, motor_turn=0, busy=0, fwd_count=0, turn_count=0 and clear the internal step timer, including mid-step.
REQ-034 SHALL resume operation on the first rising clk edge after rst_n is deasserted.

Verification
REQ-035 Bench SHALL cover: enable rises at cycle 0 with the default parameters -> sense_req=1 at cycle 1 only, cmd_ready=1 from cycle 2.
REQ-036 Bench SHALL cover: accept front=1, turn=0 -> motor_fwd=1 for 4 cycles, fwd_count 0->1, 2 settle cycles, then sense_req again.
REQ-037 Bench SHALL cover: accept front=1, turn=1 -> ROTATE, motor_turn=1 for 8 cycles, turn_count=1, fwd_count unchanged.
REQ-038 Bench SHALL cover: estop at the 3rd cycle of ROTATE -> motor_turn=0 on the next cycle, IDLE, turn_count unchanged; also rst_n pulsed mid-DRIVE -> all outputs 0 immediately.
REQ-039 Bench SHALL cover: 260 forward steps -> fwd_count saturates at 255; accepting front=0, turn=0 -> no motor activity, SETTLE, then SENSE.
